axil_reg_bridge: RTL and testbench

AXI4-Lite slave that turns host register transactions into the single-port system_reg en/we/addr/din/dout strobe interface of the configuration register file. It sits between the shell's AXI-Lite register bus and the register file. It serialises reads and writes, performs read-modify-write for partial byte strobes, and rejects out-of-range addresses. One transaction is in flight at a time.

---
 rtl/axil_reg_bridge_if.sv | 31 +++
 rtl/axil_reg_bridge.sv | 120 ++++++++++++
 tb/tb_axil_reg_bridge.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_reg_bridge_if.sv
// axil_reg_bridge_if: AXI4-Lite register bus between the host shell and the register bridge
interface axil_reg_bridge_if #(
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic awvalid;
    logic awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic wvalid;
    logic wready;
    logic [1:0] bresp;
    logic bvalid;
    logic bready;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic arvalid;
    logic arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0] rresp;
    logic rvalid;
    logic rready;
    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_reg_bridge.sv
// axil_reg_bridge: AXI4-Lite slave serialising host accesses onto a single-port en/we register strobe interface
module axil_reg_bridge #(
    parameter int ENTRIES = 12,
    parameter int DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int READ_LATENCY = 0,
    localparam int IW = $clog2(ENTRIES),
    localparam int NB = DATA_WIDTH / 8
) (
    input  logic clk,
    input  logic rst,
    axil_reg_bridge_if.slave s_axil,
    output logic system_reg_en,
    output logic system_reg_we,
    output logic [IW-1:0] system_reg_addr,
    output logic [DATA_WIDTH-1:0] system_reg_din,
    input  logic [DATA_WIDTH-1:0] system_reg_dout
);
    typedef enum logic [2:0] {IDLE, WR_STROBE, RMW_READ, RMW_WRITE, WR_RESP, RD_STROBE, RD_RESP} state_t;
    state_t state, next;
    logic idle, aw_hs, w_hs, b_hs, r_hs, wr_go, rd_go, last, wr_pri;
    logic aw_full, w_full;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr, cur_awaddr;
    logic [DATA_WIDTH-1:0] w_data, cur_wdata, merged, din, rdata;
    logic [NB-1:0] w_strb, cur_wstrb;
    logic [IW-1:0] reg_addr;
    logic [1:0] cnt, bresp, rresp;
    function automatic logic oor(input logic [AXI_ADDR_WIDTH-1:0] a);
        return (a >> 2) >= AXI_ADDR_WIDTH'(ENTRIES);
    endfunction
    assign idle = state == IDLE && !rst;
    assign s_axil.awready = idle && !aw_full;
    assign s_axil.wready = idle && !w_full;
    assign aw_hs = s_axil.awvalid && s_axil.awready;
    assign w_hs = s_axil.wvalid && s_axil.wready;
    assign cur_awaddr = aw_full ? aw_addr : s_axil.awaddr;
    assign cur_wdata = w_full ? w_data : s_axil.wdata;
    assign cur_wstrb = w_full ? w_strb : s_axil.wstrb;
    // a ready write pair yields to a pending read only when the pointer favours reads
    assign wr_go = idle && (aw_full || aw_hs) && (w_full || w_hs) && (wr_pri || !s_axil.arvalid);
    assign s_axil.arready = idle && !wr_go;
    assign rd_go = s_axil.arvalid && s_axil.arready;
    assign b_hs = s_axil.bvalid && s_axil.bready;
    assign r_hs = s_axil.rvalid && s_axil.rready;
    assign last = cnt == 2'(READ_LATENCY);
    assign s_axil.bvalid = state == WR_RESP;
    assign s_axil.rvalid = state == RD_RESP;
    assign s_axil.bresp = bresp;
    assign s_axil.rresp = rresp;
    assign s_axil.rdata = rdata;
    assign system_reg_en = state == RD_STROBE || state == RMW_READ;
    assign system_reg_we = state == WR_STROBE || state == RMW_WRITE;
    assign system_reg_addr = reg_addr;
    assign system_reg_din = din;
    always_comb begin
        merged = system_reg_dout;
        for (int i = 0; i < NB; i++)
            if (w_strb[i]) merged[8*i +: 8] = w_data[8*i +: 8];
    end
    always_comb begin
        next = state;
        case (state)
            IDLE: next = wr_go ? (oor(cur_awaddr) || cur_wstrb == '0 ? WR_RESP :
                                  cur_wstrb == '1 ? WR_STROBE : RMW_READ) :
                         rd_go ? (oor(s_axil.araddr) ? RD_RESP : RD_STROBE) : IDLE;
            WR_STROBE, RMW_WRITE: next = WR_RESP;
            RMW_READ: next = last ? RMW_WRITE : RMW_READ;
            WR_RESP: next = b_hs ? IDLE : WR_RESP;
            RD_STROBE: next = last ? RD_RESP : RD_STROBE;
            RD_RESP: next = r_hs ? IDLE : RD_RESP;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= next;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            aw_full <= 1'b0;
            w_full <= 1'b0;
            aw_addr <= '0;
            w_data <= '0;
            w_strb <= '0;
            wr_pri <= 1'b1;
            cnt <= '0;
            reg_addr <= '0;
            din <= '0;
            rdata <= '0;
            bresp <= 2'b00;
            rresp <= 2'b00;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_addr <= s_axil.awaddr;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= s_axil.wdata;
                w_strb <= s_axil.wstrb;
            end
            if (b_hs) begin
                aw_full <= 1'b0;
                w_full <= 1'b0;
            end
            if (wr_go || rd_go) wr_pri <= ~wr_pri;
            cnt <= (state == RD_STROBE || state == RMW_READ) && !last ? cnt + 2'd1 : 2'd0;
            if (wr_go) begin
                reg_addr <= cur_awaddr[2 +: IW];
                din <= cur_wdata;
                bresp <= oor(cur_awaddr) ? 2'b10 : 2'b00;
            end
            if (rd_go) begin
                reg_addr <= s_axil.araddr[2 +: IW];
                rresp <= oor(s_axil.araddr) ? 2'b10 : 2'b00;
                rdata <= '0;
            end
            if (state == RD_STROBE && last) rdata <= system_reg_dout;
            if (state == RMW_READ && last) din <= merged;
        end
endmodule

// File: tb/tb_axil_reg_bridge.sv
// tb_axil_reg_bridge: scoreboard bench for the AXI-Lite register bridge (latency 0 and latency 2 instances)
module tb_axil_reg_bridge;
    logic clk = 0, rst = 0;
    always #5 clk = ~clk;
    int checks = 0, errors = 0, en_cnt = 0, we_cnt = 0;
    axil_reg_bridge_if #(.AXI_ADDR_WIDTH(12), .DATA_WIDTH(32)) m ();
    axil_reg_bridge_if #(.AXI_ADDR_WIDTH(12), .DATA_WIDTH(32)) m2 ();
    logic en0, we0, en1, we1;
    logic [3:0] addr0, addr1;
    logic [31:0] din0, din1, dout0, dout1;
    logic [31:0] mem0 [16];
    logic [31:0] mem1 [16];
    logic [31:0] exp_mem [16];
    logic [1:0] ecnt1 = 0;
    axil_reg_bridge #(.READ_LATENCY(0)) dut (.clk(clk), .rst(rst), .s_axil(m), .system_reg_en(en0),
        .system_reg_we(we0), .system_reg_addr(addr0), .system_reg_din(din0), .system_reg_dout(dout0));
    axil_reg_bridge #(.READ_LATENCY(2)) dut2 (.clk(clk), .rst(rst), .s_axil(m2), .system_reg_en(en1),
        .system_reg_we(we1), .system_reg_addr(addr1), .system_reg_din(din1), .system_reg_dout(dout1));
    // register file models; the latency-2 model only presents valid data on the third enable cycle
    always @(posedge clk) begin
        if (we0) mem0[addr0] <= din0;
        if (we1) mem1[addr1] <= din1;
        ecnt1 <= en1 ? ecnt1 + 2'd1 : 2'd0;
    end
    assign dout0 = en0 ? mem0[addr0] : 32'hBAD0BAD0;
    assign dout1 = (en1 && ecnt1 == 2'd2) ? mem1[addr1] : 32'hBAD1BAD1;
    typedef struct packed {logic rd; logic [1:0] resp; logic [31:0] data;} rsp_t;
    typedef struct packed {logic [3:0] addr; logic [31:0] din;} stb_t;
    rsp_t rsp_q[$];
    stb_t stb_q[$];
    function automatic logic oor(input logic [11:0] a);
        return a[11:6] != 0 || a[5:2] >= 4'd12;
    endfunction
    task automatic push_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] v;
        if (oor(a)) rsp_q.push_back(rsp_t'{1'b0, 2'b10, 32'h0});
        else begin
            if (s != 0) begin
                v = exp_mem[a[5:2]];
                for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
                exp_mem[a[5:2]] = v;
                stb_q.push_back(stb_t'{a[5:2], v});
            end
            rsp_q.push_back(rsp_t'{1'b0, 2'b00, 32'h0});
        end
    endtask
    task automatic push_read(input logic [11:0] a);
        if (oor(a)) rsp_q.push_back(rsp_t'{1'b1, 2'b10, 32'h0});
        else rsp_q.push_back(rsp_t'{1'b1, 2'b00, exp_mem[a[5:2]]});
    endtask
    always @(negedge clk) begin : monitor
        rsp_t r;
        stb_t s;
        if (!rst) begin
            if (en0) en_cnt++;
            if (we0) begin
                we_cnt++;
                checks++;
                if (en0 || stb_q.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected en=%0b we=%0b addr=%0d din=%h", en0, we0, addr0, din0);
                end else begin
                    s = stb_q.pop_front();
                    if (addr0 !== s.addr || din0 !== s.din) begin
                        errors++;
                        $display("FAIL strobe got addr=%0d din=%h want addr=%0d din=%h", addr0, din0, s.addr, s.din);
                    end
                end
            end
            if (m.bvalid && m.bready) begin
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bresp_unexpected got %b", m.bresp);
                end else begin
                    r = rsp_q.pop_front();
                    if (r.rd !== 1'b0 || m.bresp !== r.resp) begin
                        errors++;
                        $display("FAIL bresp got B resp=%b want rd=%0b resp=%b", m.bresp, r.rd, r.resp);
                    end
                end
            end
            if (m.rvalid && m.rready) begin
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rresp_unexpected got %b %h", m.rresp, m.rdata);
                end else begin
                    r = rsp_q.pop_front();
                    if (r.rd !== 1'b1 || m.rresp !== r.resp || m.rdata !== r.data) begin
                        errors++;
                        $display("FAIL rresp got R resp=%b data=%h want rd=%0b resp=%b data=%h",
                                 m.rresp, m.rdata, r.rd, r.resp, r.data);
                    end
                end
            end
        end
    end
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        logic aw_ok, w_ok;
        push_write(a, d, s);
        m.awaddr = a; m.wdata = d; m.wstrb = s; m.awvalid = 1; m.wvalid = 1;
        while ((m.awvalid || m.wvalid) && n < 50) begin
            @(negedge clk); aw_ok = m.awready; w_ok = m.wready;
            @(posedge clk); #1;
            if (aw_ok) m.awvalid = 0;
            if (w_ok) m.wvalid = 0;
            n++;
        end
        checks++;
        if (m.awvalid || m.wvalid) begin
            errors++;
            $display("FAIL write_accept timeout addr=%h", a);
            m.awvalid = 0; m.wvalid = 0;
        end
    endtask
    task automatic axi_read(input logic [11:0] a);
        int n = 0;
        logic ok = 0;
        push_read(a);
        m.araddr = a; m.arvalid = 1;
        while (!ok && n < 50) begin
            @(negedge clk); ok = m.arready;
            @(posedge clk); #1;
            n++;
        end
        m.arvalid = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL read_accept timeout addr=%h", a); end
    endtask
    task automatic wait_done();
        int n = 0;
        while ((rsp_q.size() != 0 || stb_q.size() != 0) && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (rsp_q.size() != 0 || stb_q.size() != 0) begin
            errors++;
            $display("FAIL drain got rsp=%0d stb=%0d pending want 0", rsp_q.size(), stb_q.size());
            rsp_q.delete(); stb_q.delete();
        end
        @(posedge clk); #1;
    endtask
    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({m.awready, m.wready, m.arready, m.bvalid, m.rvalid, m.bresp, m.rresp} !== 9'b0 || m.rdata !== 0 ||
            {en0, we0, en1, we1} !== 4'b0 || addr0 !== 0 || din0 !== 0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b%b%b v=%b%b resp=%b%b rdata=%h en/we=%b%b addr=%0d din=%h want all 0",
                     m.awready, m.wready, m.arready, m.bvalid, m.rvalid, m.bresp, m.rresp, m.rdata, en0, we0, addr0, din0);
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if ({m.awready, m.wready, m.arready} !== 3'b111) begin
            errors++;
            $display("FAIL idle_ready got %b%b%b want 111", m.awready, m.wready, m.arready);
        end
        @(posedge clk); #1;
    endtask
    task automatic test_full_write();
        int w0 = we_cnt;
        push_write(12'h008, 32'hDEADBEEF, 4'hF);
        m.awaddr = 12'h008; m.wdata = 32'hDEADBEEF; m.wstrb = 4'hF; m.awvalid = 1; m.wvalid = 1;
        @(negedge clk);
        checks++;
        if (!(m.awready && m.wready)) begin errors++; $display("FAIL full_accept got %b%b want 11", m.awready, m.wready); end
        @(posedge clk); #1; m.awvalid = 0; m.wvalid = 0;
        @(negedge clk);
        checks++;
        if ({en0, we0, addr0, din0} !== {1'b0, 1'b1, 4'd2, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL full_strobe got en=%b we=%b addr=%0d din=%h want 0 1 2 deadbeef", en0, we0, addr0, din0);
        end
        @(negedge clk);
        checks++;
        if (m.bvalid !== 1'b1 || m.bresp !== 2'b00) begin
            errors++;
            $display("FAIL full_bvalid got %b/%b want 1/00", m.bvalid, m.bresp);
        end
        wait_done();
        checks++;
        if (we_cnt - w0 != 1) begin errors++; $display("FAIL full_count got %0d want 1", we_cnt - w0); end
    endtask
    task automatic test_rmw();
        int n = 0, w0;
        logic first_en = 0;
        logic [31:0] d = 0;
        axi_write(12'h00C, 32'h11223344, 4'hF);
        wait_done();
        push_write(12'h00C, 32'hAABBCCDD, 4'b0101);
        m.awaddr = 12'h00C; m.wdata = 32'hAABBCCDD; m.wstrb = 4'b0101; m.awvalid = 1; m.wvalid = 1;
        @(negedge clk);
        @(posedge clk); #1; m.awvalid = 0; m.wvalid = 0;
        while (n < 20) begin
            @(negedge clk); n++;
            if (n == 1) first_en = en0;
            if (we0) d = din0;
            if (m.bvalid) break;
        end
        checks++;
        if (n != 3 || first_en !== 1'b1) begin
            errors++;
            $display("FAIL rmw_latency got bvalid_cycle=%0d first_en=%b want 3 1", n, first_en);
        end
        checks++;
        if (d !== 32'h11BB33DD) begin errors++; $display("FAIL rmw_din got %h want 11bb33dd", d); end
        wait_done();
        w0 = we_cnt;
        axi_write(12'h00C, 32'hFFFFFFFF, 4'h0);
        wait_done();
        checks++;
        if (we_cnt != w0) begin errors++; $display("FAIL zero_strb got %0d strobes want 0", we_cnt - w0); end
        axi_read(12'h00C);
        wait_done();
    endtask
    task automatic test_out_of_range();
        int e0 = en_cnt, w0 = we_cnt;
        axi_read(12'h030);
        wait_done();
        axi_write(12'h800, 32'h12345678, 4'hF);
        wait_done();
        axi_write(12'h040, 32'h12345678, 4'hF);
        wait_done();
        checks++;
        if (en_cnt != e0 || we_cnt != w0) begin
            errors++;
            $display("FAIL oor_strobes got en=%0d we=%0d want 0 0", en_cnt - e0, we_cnt - w0);
        end
        axi_write(12'h02C, 32'hCAFEF00D, 4'hF);
        wait_done();
        axi_read(12'h02F);
        wait_done();
    endtask
    task automatic test_backpressure();
        int n = 0, w0 = we_cnt;
        push_write(12'h014, 32'h0BADCAFE, 4'hF);
        m.bready = 0;
        m.awaddr = 12'h014; m.awvalid = 1;
        @(negedge clk);
        @(posedge clk); #1; m.awvalid = 0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (m.awready !== 1'b0 || we0 !== 1'b0) begin
                errors++;
                $display("FAIL aw_slot_full got awready=%b we=%b want 0 0", m.awready, we0);
            end
            @(posedge clk); #1;
        end
        m.wdata = 32'h0BADCAFE; m.wstrb = 4'hF; m.wvalid = 1;
        @(negedge clk);
        @(posedge clk); #1; m.wvalid = 0;
        while (!m.bvalid && n < 20) begin @(posedge clk); #1; n++; end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (m.bvalid !== 1'b1 || m.bresp !== 2'b00 || m.awready !== 1'b0 || m.arready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold got bvalid=%b bresp=%b awready=%b arready=%b want 1 00 0 0",
                         m.bvalid, m.bresp, m.awready, m.arready);
            end
        end
        checks++;
        if (we_cnt - w0 != 1) begin errors++; $display("FAIL bp_count got %0d want 1", we_cnt - w0); end
        @(posedge clk); #1; m.bready = 1;
        wait_done();
    endtask
    task automatic test_arbitration();
        int n = 0;
        rst = 1; @(posedge clk); #1; rst = 0; @(posedge clk); #1;
        push_write(12'h010, 32'h01010101, 4'hF);
        push_read(12'h010);
        push_write(12'h010, 32'h02020202, 4'hF);
        m.awaddr = 12'h010; m.wdata = 32'h01010101; m.wstrb = 4'hF; m.awvalid = 1; m.wvalid = 1;
        m.araddr = 12'h010; m.arvalid = 1;
        @(negedge clk);
        checks++;
        if ({m.awready, m.wready, m.arready} !== 3'b110) begin
            errors++;
            $display("FAIL arb_first got %b%b%b want 110", m.awready, m.wready, m.arready);
        end
        @(posedge clk); #1; m.wdata = 32'h02020202;
        do begin @(negedge clk); n++; end while (!m.awready && n < 20);
        checks++;
        if ({m.awready, m.wready, m.arready} !== 3'b111) begin
            errors++;
            $display("FAIL arb_second got %b%b%b want 111", m.awready, m.wready, m.arready);
        end
        @(posedge clk); #1; m.awvalid = 0; m.wvalid = 0; m.arvalid = 0;
        wait_done();
        push_read(12'h010);
        push_write(12'h018, 32'h03030303, 4'hF);
        m.awaddr = 12'h018; m.wdata = 32'h03030303; m.awvalid = 1; m.wvalid = 1; m.arvalid = 1;
        @(negedge clk);
        checks++;
        if ({m.awready, m.wready, m.arready} !== 3'b111) begin
            errors++;
            $display("FAIL arb_third got %b%b%b want 111", m.awready, m.wready, m.arready);
        end
        @(posedge clk); #1; m.awvalid = 0; m.wvalid = 0; m.arvalid = 0;
        wait_done();
    endtask
    task automatic test_back_to_back();
        logic [11:0] a;
        for (int i = 0; i < 12; i++) begin
            a = 12'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if (i % 4 == 3) a[10] = 1'b1;
            axi_write(a, $urandom, 4'($urandom_range(0, 15)));
            axi_read(a);
        end
        wait_done();
    endtask
    task automatic test_latency2();
        int n_en = 0, got = 0;
        logic [31:0] rd = 0;
        logic [1:0] rr = 2'b11;
        m2.awaddr = 12'h004; m2.wdata = 32'h5; m2.wstrb = 4'hF; m2.awvalid = 1; m2.wvalid = 1;
        @(negedge clk);
        checks++;
        if (!(m2.awready && m2.wready)) begin errors++; $display("FAIL l2_wr_accept got %b%b want 11", m2.awready, m2.wready); end
        @(posedge clk); #1; m2.awvalid = 0; m2.wvalid = 0;
        repeat (4) @(posedge clk);
        #1;
        m2.araddr = 12'h004; m2.arvalid = 1;
        @(negedge clk);
        checks++;
        if (m2.arready !== 1'b1) begin errors++; $display("FAIL l2_rd_accept got %b want 1", m2.arready); end
        @(posedge clk); #1; m2.arvalid = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (en1) n_en++;
            if (m2.rvalid && got == 0) begin got = i; rd = m2.rdata; rr = m2.rresp; end
        end
        checks++;
        if (n_en != 3 || got != 4 || rd !== 32'h5 || rr !== 2'b00) begin
            errors++;
            $display("FAIL l2_read got en_cycles=%0d rvalid_cycle=%0d rdata=%h rresp=%b want 3 4 5 00", n_en, got, rd, rr);
        end
        @(posedge clk); #1;
        m2.arvalid = 1;
        @(negedge clk);
        @(posedge clk); #1; m2.arvalid = 0;
        @(negedge clk);
        checks++;
        if (en1 !== 1'b1) begin errors++; $display("FAIL l2_strobe got en=%b want 1", en1); end
        #1 rst = 1;
        #1;
        checks++;
        if (en1 !== 1'b0 || we1 !== 1'b0) begin errors++; $display("FAIL l2_reset_drop got en=%b we=%b want 0 0", en1, we1); end
        @(posedge clk); #1; rst = 0;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (m2.rvalid !== 1'b0 || en1 !== 1'b0) begin
                errors++;
                $display("FAIL l2_abandon got rvalid=%b en=%b want 0 0", m2.rvalid, en1);
            end
        end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        for (int i = 0; i < 16; i++) begin mem0[i] = 0; mem1[i] = 0; exp_mem[i] = 0; end
        m.awaddr = 0; m.awvalid = 0; m.wdata = 0; m.wstrb = 0; m.wvalid = 0; m.bready = 1;
        m.araddr = 0; m.arvalid = 0; m.rready = 1;
        m2.awaddr = 0; m2.awvalid = 0; m2.wdata = 0; m2.wstrb = 0; m2.wvalid = 0; m2.bready = 1;
        m2.araddr = 0; m2.arvalid = 0; m2.rready = 1;
        #2;
        test_reset();
        test_full_write();
        test_rmw();
        test_out_of_range();
        test_backpressure();
        test_arbitration();
        test_back_to_back();
        test_latency2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
